// File: rtl/universal_shift_register_n.sv
// WIDTH-bit universal shift register: hold/shift/rotate/asr/load/clear
// with an auto-shift sequencer that repeats a shift-class op N times.
module universal_shift_register_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] I_par,
    input  logic             MSB_in,
    input  logic             LSB_in,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_cnt,
    output logic [WIDTH-1:0] A_par,
    output logic             MSB_out,
    output logic             LSB_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    function automatic logic is_shift(input logic [2:0] m);
        return (m == M_SHR) || (m == M_SHL) || (m == M_ROR) ||
               (m == M_ROL) || (m == M_ASR);
    endfunction

    function automatic logic [WIDTH-1:0] do_op(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] par,
        input logic             msb,
        input logic             lsb
    );
        logic [WIDTH-1:0] r;
        r = a;
        unique case (m)
            M_HOLD: r = a;
            M_SHR:  r = {msb, a[WIDTH-1:1]};
            M_SHL:  r = {a[WIDTH-2:0], lsb};
            M_LOAD: r = par;
            M_ROR:  r = {a[0], a[WIDTH-1:1]};
            M_ROL:  r = {a[WIDTH-2:0], a[WIDTH-1]};
            M_ASR:  r = {a[WIDTH-1], a[WIDTH-1:1]};
            M_CLR:  r = '0;
            default: r = a;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && is_shift(mode)) begin
                    if (shift_cnt != '0) begin
                        mode_d  = mode;
                        cnt_d   = shift_cnt;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    a_d = do_op(mode, a_q, I_par, MSB_in, LSB_in);
                end
            end
            RUN: begin
                // serial inputs stay live while the latched op repeats
                a_d = do_op(mode_q, a_q, I_par, MSB_in, LSB_in);
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_q <= 1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge CLK) begin
        if (Clear) begin
            state_q <= IDLE;
            a_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= M_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign A_par   = a_q;
    assign MSB_out = a_q[WIDTH-1];
    assign LSB_out = a_q[0];
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_universal_shift_register_n.sv
// Scoreboard bench for universal_shift_register_n (WIDTH=8, CNT_W=4).
// Expected post-edge state is queued at drive time and popped after the edge.
module tb_universal_shift_register_n;

    logic       CLK;
    logic       Clear;
    logic [2:0] mode;
    logic [7:0] I_par;
    logic       MSB_in;
    logic       LSB_in;
    logic       start;
    logic [3:0] shift_cnt;
    logic [7:0] A_par;
    logic       MSB_out;
    logic       LSB_out;
    logic       busy;
    logic       done;

    typedef struct {
        string      tag;
        logic [7:0] a;
        logic       b;
        logic       d;
    } exp_t;

    exp_t sb[$];
    int   nvec;
    int   nerr;

    universal_shift_register_n #(
        .WIDTH(8),
        .CNT_W(4)
    ) dut (
        .CLK      (CLK),
        .Clear    (Clear),
        .mode     (mode),
        .I_par    (I_par),
        .MSB_in   (MSB_in),
        .LSB_in   (LSB_in),
        .start    (start),
        .shift_cnt(shift_cnt),
        .A_par    (A_par),
        .MSB_out  (MSB_out),
        .LSB_out  (LSB_out),
        .busy     (busy),
        .done     (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input string tag, input logic clr,
                       input logic [2:0] md, input logic [7:0] ip,
                       input logic msb, input logic lsb,
                       input logic st, input logic [3:0] cnt,
                       input logic [7:0] ea, input logic eb,
                       input logic ed);
        exp_t e;
        @(negedge CLK);
        Clear     = clr;
        mode      = md;
        I_par     = ip;
        MSB_in    = msb;
        LSB_in    = lsb;
        start     = st;
        shift_cnt = cnt;
        e.tag = tag;
        e.a   = ea;
        e.b   = eb;
        e.d   = ed;
        sb.push_back(e);
    endtask

    always begin
        exp_t e;
        @(posedge CLK);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, ".A"}, {24'h0, A_par}, {24'h0, e.a});
            chk({e.tag, ".msb"}, {31'h0, MSB_out}, {31'h0, e.a[7]});
            chk({e.tag, ".lsb"}, {31'h0, LSB_out}, {31'h0, e.a[0]});
            chk({e.tag, ".busy"}, {31'h0, busy}, {31'h0, e.b});
            chk({e.tag, ".done"}, {31'h0, done}, {31'h0, e.d});
        end
    end

    initial begin
        logic [7:0] rv;
        nvec      = 0;
        nerr      = 0;
        Clear     = 1'b1;
        mode      = 3'b000;
        I_par     = 8'h00;
        MSB_in    = 1'b0;
        LSB_in    = 1'b0;
        start     = 1'b0;
        shift_cnt = 4'd0;

        // reset and clear priority
        drv("rst",   1, 3'b000, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
        drv("ld",    0, 3'b011, 8'hA5, 0, 0, 0, 0, 8'hA5, 0, 0);
        drv("clr",   1, 3'b011, 8'hFF, 1, 1, 1, 3, 8'h00, 0, 0);

        // direct single-step ops
        drv("ld2",   0, 3'b011, 8'hA5, 0, 0, 0, 0, 8'hA5, 0, 0);
        drv("shr",   0, 3'b001, 8'h00, 1, 0, 0, 0, 8'hD2, 0, 0);
        drv("shl",   0, 3'b010, 8'h00, 1, 0, 0, 0, 8'hA4, 0, 0);
        drv("hold",  0, 3'b000, 8'hFF, 1, 1, 0, 0, 8'hA4, 0, 0);
        drv("ror",   0, 3'b100, 8'h00, 1, 1, 0, 0, 8'h52, 0, 0);
        drv("rol",   0, 3'b101, 8'h00, 0, 0, 0, 0, 8'hA4, 0, 0);
        drv("asr",   0, 3'b110, 8'h00, 0, 0, 0, 0, 8'hD2, 0, 0);
        drv("zero",  0, 3'b111, 8'hFF, 1, 1, 0, 0, 8'h00, 0, 0);
        drv("stld",  0, 3'b011, 8'h81, 0, 0, 1, 3, 8'h81, 0, 0);

        // auto rol x3
        drv("rolk",  0, 3'b101, 8'h00, 0, 0, 1, 3, 8'h81, 1, 0);
        drv("rol1",  0, 3'b000, 8'h00, 0, 0, 0, 0, 8'h03, 1, 0);
        drv("rol2",  0, 3'b011, 8'hFF, 1, 1, 1, 7, 8'h06, 1, 0);
        drv("rol3",  0, 3'b111, 8'h00, 0, 0, 0, 0, 8'h0C, 0, 1);
        drv("rolh",  0, 3'b000, 8'h00, 0, 0, 0, 0, 8'h0C, 0, 0);

        // auto asr x2 with mode toggled mid-run, then back-to-back start
        drv("ld90",  0, 3'b011, 8'h90, 0, 0, 0, 0, 8'h90, 0, 0);
        drv("asrk",  0, 3'b110, 8'h00, 0, 0, 1, 2, 8'h90, 1, 0);
        drv("asr1",  0, 3'b011, 8'hFF, 1, 1, 1, 9, 8'hC8, 1, 0);
        drv("asr2",  0, 3'b111, 8'h00, 1, 1, 0, 0, 8'hE4, 0, 1);
        drv("b2bk",  0, 3'b001, 8'h00, 1, 1, 1, 1, 8'hE4, 1, 0);
        drv("b2b1",  0, 3'b000, 8'h00, 0, 1, 0, 0, 8'h72, 0, 1);

        // abort a run with Clear: no done pulse
        drv("ld0f",  0, 3'b011, 8'h0F, 0, 0, 0, 0, 8'h0F, 0, 0);
        drv("abk",   0, 3'b001, 8'h00, 1, 0, 1, 5, 8'h0F, 1, 0);
        drv("ab1",   0, 3'b000, 8'h00, 1, 0, 0, 0, 8'h87, 1, 0);
        drv("ab2",   0, 3'b000, 8'h00, 1, 0, 0, 0, 8'hC3, 1, 0);
        drv("abclr", 1, 3'b000, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0);
        drv("abh",   0, 3'b000, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0);

        // zero count: immediate done, A unchanged, never busy
        drv("ld3c",  0, 3'b011, 8'h3C, 0, 0, 0, 0, 8'h3C, 0, 0);
        drv("z0",    0, 3'b010, 8'h00, 1, 1, 1, 0, 8'h3C, 0, 1);
        drv("z1",    0, 3'b000, 8'h00, 1, 1, 0, 0, 8'h3C, 0, 0);

        // maximum count: 15 rotations of 8'h01
        drv("ld01",  0, 3'b011, 8'h01, 0, 0, 0, 0, 8'h01, 0, 0);
        drv("mxk",   0, 3'b101, 8'h00, 0, 0, 1, 15, 8'h01, 1, 0);
        for (int i = 1; i <= 15; i++) begin
            rv = 8'h01 << (i % 8);
            drv("mx", 0, 3'b000, 8'h00, 0, 0, 0, 0, rv,
                (i < 15), (i == 15));
        end
        drv("mxh",   0, 3'b000, 8'h00, 0, 0, 0, 0, 8'h80, 0, 0);

        repeat (3) @(posedge CLK);
        #2;
        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
